uart_rx_oversampler: RTL and testbench
======================================

# uart_rx_oversampler

Parametrised oversampling front end for the UART receiver. It synchronises the raw serial line, runs its own per-bit edge counter at the oversampling clock, and majority-votes a prescale-dependent window around mid-bit. It delivers one registered bit per bit period with valid, noise and end-of-bit strobes to the RX control FSM. It supersedes the fixed 8/16/32 three-clock sampler with a single-clock, width-generic block.

## Interface

Parameters:
- CNT_W, 6: edge-counter width. The largest legal prescale is 2^(CNT_W-1); with the default, that is 32.
- SYNC_STAGES, 2: flops in the rx_in synchroniser. Minimum 1.

Ports:
- clk  in  1  oversampling clock; the only clock.
- rst  in  1  reset, asynchronous, active-low.
- rx_in  in  1  raw serial line, asynchronous to clk.
- prescale  in  CNT_W  oversampling ratio. Legal values are powers of two from 8 to 2^(CNT_W-1).
- sample_en  in  1  high while the RX FSM wants bits sampled.
- sampled_bit  out  1  voted bit value, registered.
- bit_valid  out  1  one-cycle strobe; sampled_bit and noise_err are valid in that cycle.
- noise_err  out  1  the window votes were not unanimous.
- bit_done  out  1  one-cycle strobe on the last edge of a bit period.
- edge_cnt  out  CNT_W  current edge index within the bit.
- cfg_err  out  1  the latched prescale is illegal.

## Operation

- The synchroniser chain resets to 1 (line idle). Its output is rx_s.
- Prescale latch: P is captured from prescale in the cycle where sample_en is high and was low in the previous cycle. Later prescale changes are ignored until the next enable rise.
- Legality check on the latched P:
  - P not a legal power of two raises cfg_err.
  - While cfg_err is high: edge_cnt is held at 0, no strobes are issued, and cfg_err stays high until sample_en falls.
- Half-width h = log2(P) - 2. This gives 8→1, 16→2, 32→3, 64→4.
- The vote window is edges P/2-h through P/2+h, which is 2h+1 samples.
- Edge counter:
  - Holds 0 while sample_en is low.
  - Reads 0 in the first enabled cycle.
  - Increments by 1 per clk and wraps from P-1 to 0.
- Ones counter:
  - Adds rx_s on each window edge.
  - Clears when edge_cnt wraps, and while sample_en is low.
  - Width is clog2(2*hmax+2).
- Decision, registered in the cycle after edge P/2+h:
  - sampled_bit = 1 when ones > h.
  - noise_err = 1 when ones is neither 0 nor 2h+1.
  - bit_valid pulses for one cycle.
- bit_done is registered and pulses in the cycle following edge_cnt == P-1.
- sample_en falling mid-bit:
  - Counters clear on the next clk.
  - A pending bit_valid or bit_done that was already registered still completes.
  - No further strobes are issued.
- sample_en rising in the same cycle as a bit_done pulse starts a fresh count at 0.
- Reset values (async assert): all outputs 0, edge_cnt 0, latched P 0, synchroniser stages 1.

## Timing

- rx_in to rx_s latency is SYNC_STAGES cycles.
- bit_valid fires at window end + 1. Example, P=16: window is edges 6..10, bit_valid is high during the cycle where edge_cnt == 11.
- bit_done fires once every P cycles, on the cycle where edge_cnt == 0 after the wrap.
- Throughput is one bit per P cycles, with no bubbles across consecutive bits.
- Reset deassertion is synchronised externally; the block makes no assumption about the first-edge alignment.

## Structure

- Package uart_pkg holds:
  - the function is_legal_prescale(P, CNT_W);
  - the function half_width(P) implementing log2(P)-2;
  - the local constant HMAX = CNT_W-3;
  - the vote-counter width derived from HMAX.
- Sub-module uart_rx_sync: a SYNC_STAGES-deep flop chain with async reset to 1. It is reused by the baud detector.
- The top level contains the prescale latch, edge counter, ones counter and decision registers.

## Test plan

- P=16, rx_in held 1 for 3 bit periods, then 0 for 2:
  - Expect bit_valid at edge 11 of each bit.
  - Expect sampled_bit = 1,1,1,0,0.
  - Expect noise_err = 0 throughout.
- P=8, rx_in glitched to 0 on edge 4 only → sampled_bit=1, noise_err=1.
- P=32, rx_in 0 on edges 13..15 and 1 on edges 16..19 → ones=4, sampled_bit=1, noise_err=1.
- prescale=12 at enable rise:
  - Expect cfg_err=1, edge_cnt stuck at 0, and no strobes.
  - Drop sample_en, re-enable with prescale=8: expect cfg_err=0 and normal sampling.
- sample_en dropped at edge 7 with P=16 → edge_cnt=0 next cycle and no bit_valid for that bit. Change prescale to 32 while enabled → period remains 16 until re-enable.
- rst asserted mid-window at edge 8 → all outputs 0 immediately. After release with sample_en high, edge_cnt restarts from 0 with no spurious bit_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path.
// Vote-window geometry is derived from the prescale ratio.
package uart_pkg;
  localparam int CNT_W_DEF = 6;
  localparam int HMAX      = CNT_W_DEF - 3;
  localparam int VOTE_W    = $clog2(2*HMAX + 2);

  function automatic int hmax(input int cnt_w);
    return cnt_w - 3;
  endfunction

  function automatic int vote_w(input int cnt_w);
    return $clog2(2*hmax(cnt_w) + 2);
  endfunction

  // Legal ratios are powers of two from 8 up to 2^(cnt_w-1).
  function automatic logic is_legal_prescale(input logic [31:0] p, input int cnt_w);
    logic pow2;
    pow2 = (p != 32'd0) && ((p & (p - 32'd1)) == 32'd0);
    return pow2 && (p >= 32'd8) && (p <= (32'd1 << (cnt_w - 1)));
  endfunction

  // log2(p) - 2: 8->1, 16->2, 32->3, 64->4.
  function automatic int half_width(input logic [31:0] p);
    int lg;
    lg = 0;
    for (int i = 0; i < 32; i++)
      if (p[i]) lg = i;
    return lg - 2;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous serial line; resets to idle (1).
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = STAGES'({sync_q, d});

  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= '1;
    else      sync_q <= sync_d;

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx_oversampler.sv
// Oversampling bit recovery: prescale latch, per-bit edge counter, windowed
// majority vote around mid-bit, and registered valid/noise/done strobes.
module uart_rx_oversampler
  import uart_pkg::*;
#(
  parameter int CNT_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  input  logic [CNT_W-1:0] prescale,
  input  logic             sample_en,
  output logic             sampled_bit,
  output logic             bit_valid,
  output logic             noise_err,
  output logic             bit_done,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cfg_err
);
  localparam int VW = vote_w(CNT_W);

  logic rx_s;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  logic             en_q;
  logic [CNT_W-1:0] p_q, p_d, cnt_q, cnt_d;
  logic [VW-1:0]    ones_q, ones_d;
  logic             bit_q, bit_d, vld_q, vld_d, noise_q, noise_d;
  logic             done_q, done_d, cfg_q, cfg_d;

  logic             rise, legal, active, wrap, in_win, win_end;
  logic [CNT_W-1:0] p_eff, mid, h_c;
  logic [VW-1:0]    ones_new, full;
  int               hw;

  always_comb begin
    rise  = sample_en && !en_q;
    // The new ratio must already govern the rise cycle itself.
    p_eff = rise ? prescale : p_q;
    p_d   = p_eff;
    legal = is_legal_prescale(32'(p_eff), CNT_W);
    active = sample_en && legal;

    hw   = half_width(32'(p_eff));
    h_c  = CNT_W'(hw);
    mid  = p_eff >> 1;
    full = VW'(2*hw + 1);

    wrap    = (cnt_q == p_eff - CNT_W'(1));
    in_win  = (cnt_q >= mid - h_c) && (cnt_q <= mid + h_c);
    win_end = (cnt_q == mid + h_c);

    ones_new = in_win ? ones_q + VW'(rx_s) : ones_q;

    cnt_d  = (active && !wrap) ? cnt_q + CNT_W'(1) : '0;
    ones_d = (active && !wrap) ? ones_new : '0;

    vld_d   = active && win_end;
    done_d  = active && wrap;
    bit_d   = vld_d ? (ones_new > VW'(hw)) : bit_q;
    noise_d = vld_d ? ((ones_new != '0) && (ones_new != full)) : noise_q;
    cfg_d   = sample_en && !legal;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      en_q    <= 1'b0;
      p_q     <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
      noise_q <= 1'b0;
      done_q  <= 1'b0;
      cfg_q   <= 1'b0;
    end else begin
      en_q    <= sample_en;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
      noise_q <= noise_d;
      done_q  <= done_d;
      cfg_q   <= cfg_d;
    end

  assign sampled_bit = bit_q;
  assign bit_valid   = vld_q;
  assign noise_err   = noise_q;
  assign bit_done    = done_q;
  assign edge_cnt    = cnt_q;
  assign cfg_err     = cfg_q;
endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Bench for uart_rx_oversampler: directed and randomized line patterns scored
// against a bit-period model of the vote window and strobe timing.
module tb_uart_rx_oversampler;
  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       sample_en;
  logic       sampled_bit, bit_valid, noise_err, bit_done, cfg_err;
  logic [5:0] edge_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  bit pat [256];   // intended synchronised line value at each cycle after enable

  uart_rx_oversampler #(.CNT_W(6), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .sample_en   (sample_en),
    .sampled_bit (sampled_bit),
    .bit_valid   (bit_valid),
    .noise_err   (noise_err),
    .bit_done    (bit_done),
    .edge_cnt    (edge_cnt),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic void fill(input bit v);
    for (int i = 0; i < 256; i++) pat[i] = v;
  endfunction

  // Enable with ratio p, stream nbits bit periods of pat, score every cycle.
  task automatic run_bits(input int p, input int nbits, input int p_new);
    int h, k, e, ones;
    bit exp_v, exp_d, exp_b, exp_n;
    h = $clog2(p) - 2;
    rx_in = pat[0]; @(posedge clk); #1;
    rx_in = pat[1]; @(posedge clk); #1;
    prescale = 6'(p); sample_en = 1'b1; rx_in = pat[2];
    for (int j = 0; j <= nbits*p; j++) begin
      @(negedge clk);
      e = j % p; k = j / p;
      exp_v = (e == p/2 + h + 1);
      exp_d = (j > 0) && (e == 0);
      ones = 0;
      for (int i = p/2 - h; i <= p/2 + h; i++) ones += int'(pat[k*p + i]);
      exp_b = (ones > h);
      exp_n = (ones != 0) && (ones != 2*h + 1);
      n_chk++;
      if (edge_cnt !== 6'(e)) $display("FAIL edge_cnt p=%0d j=%0d got %0d exp %0d", p, j, edge_cnt, e);
      else n_pass++;
      n_chk++;
      if (bit_valid !== exp_v) $display("FAIL bit_valid p=%0d j=%0d got %b exp %b", p, j, bit_valid, exp_v);
      else n_pass++;
      n_chk++;
      if (bit_done !== exp_d) $display("FAIL bit_done p=%0d j=%0d got %b exp %b", p, j, bit_done, exp_d);
      else n_pass++;
      n_chk++;
      if (cfg_err !== 1'b0) $display("FAIL cfg_err_run p=%0d j=%0d got %b exp 0", p, j, cfg_err);
      else n_pass++;
      if (exp_v) begin
        n_chk++;
        if (sampled_bit !== exp_b) $display("FAIL sampled_bit p=%0d bit=%0d got %b exp %b", p, k, sampled_bit, exp_b);
        else n_pass++;
        n_chk++;
        if (noise_err !== exp_n) $display("FAIL noise_err p=%0d bit=%0d got %b exp %b", p, k, noise_err, exp_n);
        else n_pass++;
      end
      @(posedge clk); #1;
      rx_in = pat[j+3];
      if (j == 3 && p_new != 0) prescale = 6'(p_new);
    end
    sample_en = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bit_valid !== 1'b0 || bit_done !== 1'b0) $display("FAIL strobe_after_fall got v=%b d=%b exp 0", bit_valid, bit_done);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (edge_cnt !== 6'd0) $display("FAIL edge_cnt_idle got %0d exp 0", edge_cnt);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if ({sampled_bit, bit_valid, noise_err, bit_done, edge_cnt, cfg_err} !== 11'd0)
      $display("FAIL reset_outputs got %b exp 0", {sampled_bit, bit_valid, noise_err, bit_done, edge_cnt, cfg_err});
    else n_pass++;
    @(posedge clk); #1; rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bit_valid, bit_done, edge_cnt, cfg_err} !== 9'd0)
      $display("FAIL idle_outputs got %b exp 0", {bit_valid, bit_done, edge_cnt, cfg_err});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_steady();
    for (int i = 0; i < 256; i++) pat[i] = (i < 48);
    run_bits(16, 5, 0);
  endtask

  task automatic test_glitch();
    fill(1'b1); pat[4] = 1'b0;
    run_bits(8, 1, 0);
    fill(1'b1);
    for (int i = 13; i <= 15; i++) pat[i] = 1'b0;
    run_bits(32, 1, 0);
  endtask

  task automatic test_random();
    int p, nb, b;
    for (int r = 0; r < 6; r++) begin
      p  = 8 << $urandom_range(0, 2);
      nb = $urandom_range(2, 4);
      for (int i = 0; i < 256; i++) begin
        b = (i / p) < 8 ? int'($urandom_range(0, 1)) : 1;
        if (i % p == 0 || i < p) pat[i] = bit'(b);
        else pat[i] = pat[i-1];
      end
      // Re-roll per-bit values, then sprinkle isolated flips.
      for (int k = 0; k < 8; k++) begin
        b = int'($urandom_range(0, 1));
        for (int i = 0; i < p && k*p + i < 256; i++) pat[k*p + i] = bit'(b);
      end
      for (int i = 0; i < 256; i++)
        if ($urandom_range(0, 7) == 0) pat[i] = ~pat[i];
      run_bits(p, nb, 0);
    end
  endtask

  task automatic test_cfg_err();
    prescale = 6'd12; sample_en = 1'b1; rx_in = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j >= 1) begin
        n_chk++;
        if (cfg_err !== 1'b1) $display("FAIL cfg_err_set j=%0d got %b exp 1", j, cfg_err);
        else n_pass++;
      end
      n_chk++;
      if (edge_cnt !== 6'd0 || bit_valid !== 1'b0 || bit_done !== 1'b0)
        $display("FAIL cfg_hold j=%0d got cnt=%0d v=%b d=%b exp 0", j, edge_cnt, bit_valid, bit_done);
      else n_pass++;
      @(posedge clk); #1;
    end
    sample_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (cfg_err !== 1'b0) $display("FAIL cfg_err_clear got %b exp 0", cfg_err);
    else n_pass++;
    @(posedge clk); #1;
    fill(1'b1);
    for (int i = 16; i < 24; i++) pat[i] = 1'b0;
    run_bits(8, 4, 0);
  endtask

  task automatic test_abort();
    prescale = 6'd16; sample_en = 1'b1; rx_in = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      n_chk++;
      if (edge_cnt !== 6'(j < 8 ? j : 0)) $display("FAIL abort_cnt j=%0d got %0d exp %0d", j, edge_cnt, (j < 8 ? j : 0));
      else n_pass++;
      n_chk++;
      if (bit_valid !== 1'b0 || bit_done !== 1'b0) $display("FAIL abort_strobe j=%0d got v=%b d=%b exp 0", j, bit_valid, bit_done);
      else n_pass++;
      @(posedge clk); #1;
      if (j == 6) sample_en = 1'b0;
    end
    // Mid-run prescale change must not alter the latched period.
    fill(1'b0);
    for (int i = 16; i < 32; i++) pat[i] = 1'b1;
    run_bits(16, 3, 32);
  endtask

  task automatic test_reset_mid();
    prescale = 6'd16; sample_en = 1'b1; rx_in = 1'b1;
    repeat (24) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (edge_cnt !== 6'd8 || sampled_bit !== 1'b1) $display("FAIL pre_reset got cnt=%0d bit=%b exp 8/1", edge_cnt, sampled_bit);
    else n_pass++;
    rst = 1'b0; #1;
    n_chk++;
    if ({sampled_bit, bit_valid, noise_err, bit_done, edge_cnt, cfg_err} !== 11'd0)
      $display("FAIL async_reset got %b exp 0", {sampled_bit, bit_valid, noise_err, bit_done, edge_cnt, cfg_err});
    else n_pass++;
    @(posedge clk); #1; rst = 1'b1;
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      n_chk++;
      if (edge_cnt !== 6'(j % 16) || bit_valid !== (j == 11) || bit_done !== (j == 16))
        $display("FAIL post_reset j=%0d got cnt=%0d v=%b d=%b", j, edge_cnt, bit_valid, bit_done);
      else n_pass++;
      if (j == 11) begin
        n_chk++;
        if (sampled_bit !== 1'b1 || noise_err !== 1'b0) $display("FAIL post_reset_bit got %b/%b exp 1/0", sampled_bit, noise_err);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    sample_en = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; sample_en = 1'b0; rx_in = 1'b1; prescale = '0;
    test_reset();
    test_steady();
    test_glitch();
    test_random();
    test_cfg_err();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
